identity_response_checker: RTL and testbench
============================================

// Module: identity_response_checker
// PURPOSE
//  Response end of the identity-simulation flow: samples the outputs of a reference DUT and of a
//  synthesised DUT every valid clock, counts mismatches, records the first divergence, and
//  compresses the DUT response into a MISR signature. Runs for a programmed number of samples.
//  Replaces per-cycle $strobe dumps and text diffs with one self-checking pass/fail plus signature.
// PARAMETERS
//  WIDTH  81                    response width (y is [80:0])
//  CNT_W  16                    sample counter / mismatch counter width
//  POLY   {{(WIDTH-2){1'b0}},2'b11}  MISR feedback polynomial, XORed in when sig MSB is 1
//  SEED   {WIDTH{1'b0}}         MISR value loaded on start
// PORTS
//  clk               in   1      rising-edge clock
//  rst               in   1      synchronous, active-high reset
//  start             in   1      pulse: arm a run (accepted in IDLE and DONE only)
//  num_cycles        in   CNT_W  samples per run, latched on accepted start
//  valid             in   1      y_ref/y_dut hold a sample this cycle
//  y_ref             in   WIDTH  reference DUT output
//  y_dut             in   WIDTH  synthesised DUT output
//  busy              out  1      high in RUN
//  done              out  1      high in DONE
//  pass              out  1      done && mismatch_count==0
//  mismatch_count    out  CNT_W  mismatching samples, saturates at all-ones
//  first_fail_cycle  out  CNT_W  sample index (0-based) of first mismatch
//  first_fail_diff   out  WIDTH  y_ref ^ y_dut at first mismatch
//  signature         out  WIDTH  MISR over y_dut
// BEHAVIOUR
//  - All outputs registered. Reset (rst=1 at an edge, in any state, mid-run included): state IDLE,
//    busy=0, done=0, pass=0, counters 0, first_fail_* 0, signature=SEED, latched count 0.
//  - FSM IDLE -> RUN: start=1 and num_cycles!=0; latch num_cycles, clear sample idx, mismatch_count,
//    first_fail_*, load signature=SEED. busy=1 from the next cycle.
//  - IDLE/DONE with start=1 and num_cycles==0: go to DONE directly, counters cleared, sig=SEED, pass=1.
//  - RUN: start ignored. Each cycle with valid=1 takes one sample:
//      diff = y_ref ^ y_dut; if diff!=0: mismatch_count++ (saturating); if first mismatch of the run,
//      first_fail_cycle<=idx, first_fail_diff<=diff.
//      signature <= ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0)) ^ y_dut.
//      idx++. valid=0 cycles change nothing.
//  - The sample where idx+1 == latched count is the last: same edge enters DONE, so done=1 and pass
//    are visible one cycle after the last valid-sampled edge. Samples after that are ignored.
//  - DONE: outputs hold until rst or an accepted start (start in DONE re-arms directly to RUN,
//    clearing results on that edge; done drops the next cycle).
//  - "first mismatch" tracked by an internal flag, not by mismatch_count, so saturation is harmless.
//  - X/Z on inputs are not specially handled; bench drives known values only.
// TESTING
//  1 rst, start num_cycles=4, 4 valid equal samples -> done=1 one cycle after 4th, pass=1, count=0.
//  2 WIDTH=4,POLY=4'h3,SEED=0; y_dut=1,1,8,0 (y_ref equal) -> signature 4'hF, pass=1.
//  3 num_cycles=5, samples 2 and 4 differ by diff=81'h5 and 81'h1 -> count=2, first_fail_cycle=2,
//    first_fail_diff=81'h5, pass=0.
//  4 num_cycles=3 with valid low on alternate cycles -> done exactly after 3rd valid, no early done.
//  5 rst asserted mid-RUN after 2 mismatches -> next cycle all outputs at reset values; start in RUN
//    ignored; start in DONE re-arms and clears results.
//  6 CNT_W=2, num_cycles=3 all mismatching, then num_cycles=0 start -> count=3 (sat); then done, pass=1.

Source files
------------

// File: rtl/identity_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : identity_response_checker
//  Description : Response end of the identity-simulation flow. Compares a
//                reference response against a synthesised-DUT response on
//                every valid sample, counts mismatches, records the first
//                divergence and folds the DUT response into a MISR signature
//                over a programmed number of samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module identity_response_checker #(
    parameter int                 WIDTH = 81,
    parameter int                 CNT_W = 16,
    parameter logic [WIDTH-1:0]   POLY  = {{(WIDTH-2){1'b0}}, 2'b11},
    parameter logic [WIDTH-1:0]   SEED  = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_cycles,
    input  logic               valid,
    input  logic [WIDTH-1:0]   y_ref,
    input  logic [WIDTH-1:0]   y_dut,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   mismatch_count,
    output logic [CNT_W-1:0]   first_fail_cycle,
    output logic [WIDTH-1:0]   first_fail_diff,
    output logic [WIDTH-1:0]   signature
);

    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_RUN   = 2'd1;
    localparam logic [1:0]       c_ST_DONE  = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_W_ZERO   = {WIDTH{1'b0}};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;      // samples requested for the current run
    logic [CNT_W-1:0] r_idx;        // samples taken so far in this run
    logic [CNT_W-1:0] r_mismatch;
    logic [CNT_W-1:0] r_ff_cycle;
    logic [WIDTH-1:0] r_ff_diff;
    logic [WIDTH-1:0] r_sig;
    logic             r_seen;       // a mismatch has already been recorded this run
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic [WIDTH-1:0] w_diff;
    logic             w_mismatch;
    logic [WIDTH-1:0] w_sig_next;
    logic [CNT_W-1:0] w_mismatch_next;
    logic [CNT_W-1:0] w_idx_next;
    logic             w_last;

    // Per-sample datapath: difference, next MISR value, saturating count, last-sample detect
    always_comb begin
        w_diff          = y_ref ^ y_dut;
        w_mismatch      = |w_diff;
        w_sig_next      = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : c_W_ZERO) ^ y_dut;
        w_mismatch_next = (w_mismatch && !(&r_mismatch)) ? (r_mismatch + c_CNT_ONE) : r_mismatch;
        w_idx_next      = r_idx + c_CNT_ONE;
        w_last          = (w_idx_next == r_count);
    end

    // Run-control FSM and all result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_count    <= c_CNT_ZERO;
            r_idx      <= c_CNT_ZERO;
            r_mismatch <= c_CNT_ZERO;
            r_ff_cycle <= c_CNT_ZERO;
            r_ff_diff  <= c_W_ZERO;
            r_sig      <= SEED;
            r_seen     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        // Any accepted start clears the previous run's results
                        r_count    <= num_cycles;
                        r_idx      <= c_CNT_ZERO;
                        r_mismatch <= c_CNT_ZERO;
                        r_ff_cycle <= c_CNT_ZERO;
                        r_ff_diff  <= c_W_ZERO;
                        r_sig      <= SEED;
                        r_seen     <= 1'b0;
                        if (num_cycles != c_CNT_ZERO) begin
                            r_state <= c_ST_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end else begin
                            // A zero-length run completes immediately and trivially passes
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (valid) begin
                        r_mismatch <= w_mismatch_next;
                        r_sig      <= w_sig_next;
                        r_idx      <= w_idx_next;
                        if (w_mismatch && !r_seen) begin
                            r_seen     <= 1'b1;
                            r_ff_cycle <= r_idx;
                            r_ff_diff  <= w_diff;
                        end
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_mismatch_next == c_CNT_ZERO);
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign mismatch_count   = r_mismatch;
    assign first_fail_cycle = r_ff_cycle;
    assign first_fail_diff  = r_ff_diff;
    assign signature        = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_identity_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_identity_response_checker
//  Description : Scoreboard bench for identity_response_checker. Stimulus
//                pushes the expected run result; a monitor pops and compares
//                on every rising done. Two small instances cover the 4-bit
//                MISR example and the 2-bit counter case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_identity_response_checker;

    localparam int             c_W    = 81;
    localparam int             c_CW   = 16;
    localparam logic [c_W-1:0] c_POLY = {{(c_W-2){1'b0}}, 2'b11};

    typedef struct {
        logic [c_CW-1:0] cnt;
        logic [c_CW-1:0] ffc;
        logic [c_W-1:0]  ffd;
        logic [c_W-1:0]  sig;
        logic            pass;
        int              done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t           q[$];
    logic [c_W-1:0] g_refs[$];
    logic [c_W-1:0] g_duts[$];

    // Main instance
    logic            start = 1'b0;
    logic [c_CW-1:0] num_cycles = '0;
    logic            valid = 1'b0;
    logic [c_W-1:0]  y_ref = '0;
    logic [c_W-1:0]  y_dut = '0;
    logic            busy, done, pass;
    logic [c_CW-1:0] mismatch_count, first_fail_cycle;
    logic [c_W-1:0]  first_fail_diff, signature;

    identity_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles), .valid(valid),
        .y_ref(y_ref), .y_dut(y_dut), .busy(busy), .done(done), .pass(pass),
        .mismatch_count(mismatch_count), .first_fail_cycle(first_fail_cycle),
        .first_fail_diff(first_fail_diff), .signature(signature)
    );

    // 4-bit instance for the hand-worked MISR example
    logic        a_start = 1'b0, a_valid = 1'b0;
    logic [15:0] a_num = '0;
    logic [3:0]  a_ref = '0, a_dut = '0;
    logic        a_busy, a_done, a_pass;
    logic [15:0] a_cnt, a_ffc;
    logic [3:0]  a_ffd, a_sig;

    identity_response_checker #(.WIDTH(4), .CNT_W(16), .POLY(4'h3), .SEED(4'h0)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .num_cycles(a_num), .valid(a_valid),
        .y_ref(a_ref), .y_dut(a_dut), .busy(a_busy), .done(a_done), .pass(a_pass),
        .mismatch_count(a_cnt), .first_fail_cycle(a_ffc),
        .first_fail_diff(a_ffd), .signature(a_sig)
    );

    // 2-bit-counter instance for the saturation / zero-length case
    logic        b_start = 1'b0, b_valid = 1'b0;
    logic [1:0]  b_num = '0;
    logic [3:0]  b_ref = '0, b_dut = '0;
    logic        b_busy, b_done, b_pass;
    logic [1:0]  b_cnt, b_ffc;
    logic [3:0]  b_ffd, b_sig;

    identity_response_checker #(.WIDTH(4), .CNT_W(2), .POLY(4'h3), .SEED(4'h0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .num_cycles(b_num), .valid(b_valid),
        .y_ref(b_ref), .y_dut(b_dut), .busy(b_busy), .done(b_done), .pass(b_pass),
        .mismatch_count(b_cnt), .first_fail_cycle(b_ffc),
        .first_fail_diff(b_ffd), .signature(b_sig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [c_W-1:0] rand81();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[c_W-1:0];
    endfunction

    // Reference model: result of a whole run from the sample list
    function automatic exp_t model();
        exp_t           e;
        logic [c_W-1:0] d;
        bit             seen;
        e.cnt = '0; e.ffc = '0; e.ffd = '0; e.sig = '0; seen = 0;
        for (int i = 0; i < g_refs.size(); i++) begin
            d = g_refs[i] ^ g_duts[i];
            if (d != '0) begin
                if (e.cnt != {c_CW{1'b1}}) e.cnt = e.cnt + 1'b1;
                if (!seen) begin
                    seen  = 1;
                    e.ffc = c_CW'(i);
                    e.ffd = d;
                end
            end
            // MISR step: shift left, fold polynomial on carry-out, absorb sample
            e.sig = (e.sig << 1) ^ (e.sig[c_W-1] ? c_POLY : '0) ^ g_duts[i];
        end
        e.pass     = (e.cnt == '0);
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic gen_random(input int n, input int pmis);
        logic [c_W-1:0] r, m;
        g_refs.delete();
        g_duts.delete();
        for (int i = 0; i < n; i++) begin
            r = rand81();
            m = '0;
            if ($urandom_range(99) < pmis) begin
                m = rand81();
                if (m == '0) m = 1;
            end
            g_refs.push_back(r);
            g_duts.push_back(r ^ m);
        end
    endtask

    // Drive one full run from g_refs/g_duts and push its expected result
    task automatic run_main(input bit gaps);
        exp_t e;
        int   n;
        e = model();
        n = g_refs.size();
        @(negedge clk);
        start = 1'b1; num_cycles = c_CW'(n); valid = 1'b0;
        if (n == 0) begin
            e.done_cyc = cyc + 1;
            q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            while (gaps && $urandom_range(1) == 1) begin
                valid = 1'b0;
                y_ref = rand81(); y_dut = rand81();
                start = ($urandom_range(1) == 1);   // must be ignored in RUN
                num_cycles = c_CW'($urandom_range(0, 20));
                @(negedge clk);
                start = 1'b0;
            end
            valid = 1'b1; y_ref = g_refs[i]; y_dut = g_duts[i];
            if (i == n - 1) begin
                e.done_cyc = cyc + 1;
                q.push_back(e);
            end
        end
        // Trailing samples after the last one must not disturb the result
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b0; valid = 1'b1; y_ref = rand81(); y_dut = rand81();
        end
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < 30 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", 128'(q.size()), 128'd0);
            q.delete();
        end
    endtask

    // Monitor: compare each completed run against the scoreboard
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !prev_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 128'd1, 128'd0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", 128'(cyc), 128'(e.done_cyc));
                chk("busy_at_done", 128'(busy), 128'd0);
                chk("mismatch_count", 128'(mismatch_count), 128'(e.cnt));
                chk("first_fail_cycle", 128'(first_fail_cycle), 128'(e.ffc));
                chk("first_fail_diff", 128'(first_fail_diff), 128'(e.ffd));
                chk("signature", 128'(signature), 128'(e.sig));
                chk("pass", 128'(pass), 128'(e.pass));
            end
        end
        prev_done = done;
    end

    task automatic chk_main_reset();
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_pass", 128'(pass), 128'd0);
        chk("rst_count", 128'(mismatch_count), 128'd0);
        chk("rst_ffc", 128'(first_fail_cycle), 128'd0);
        chk("rst_ffd", 128'(first_fail_diff), 128'd0);
        chk("rst_sig", 128'(signature), 128'd0);
    endtask

    initial begin
        logic [3:0] a_seq [4];
        logic [3:0] b_seq [3];
        a_seq = '{4'h1, 4'h1, 4'h8, 4'h0};
        b_seq = '{4'h5, 4'hA, 4'hF};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_main_reset();

        // Four equal samples back to back
        gen_random(4, 0);
        run_main(1'b0);

        // Five samples, mismatches at index 2 (diff 5) and 4 (diff 1)
        gen_random(5, 0);
        g_duts[2] = g_refs[2] ^ 81'h5;
        g_duts[4] = g_refs[4] ^ 81'h1;
        run_main(1'b0);

        // Three samples with valid low on alternate cycles, re-armed from DONE
        gen_random(3, 50);
        run_main(1'b1);

        // Randomized runs, each re-arming directly from DONE
        for (int r = 0; r < 14; r++) begin
            gen_random($urandom_range(1, 12), (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 30 : 100));
            run_main(r % 2 == 1);
        end

        // Reset in the middle of a run with two mismatches already taken
        gen_random(6, 0);
        g_duts[0] = g_refs[0] ^ 81'h3;
        g_duts[1] = g_refs[1] ^ 81'h10;
        @(negedge clk);
        start = 1'b1; num_cycles = 16'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0; valid = 1'b1; y_ref = g_refs[i]; y_dut = g_duts[i];
        end
        @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_main_reset();
        repeat (2) @(negedge clk);
        chk("idle_after_rst_done", 128'(done), 128'd0);

        // Zero-length run from IDLE
        g_refs.delete();
        g_duts.delete();
        run_main(1'b0);

        // Normal run after that
        gen_random(7, 40);
        run_main(1'b1);

        // 4-bit MISR example: y_dut = 1,1,8,0 gives signature F
        @(negedge clk);
        a_start = 1'b1; a_num = 16'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_start = 1'b0; a_valid = 1'b1; a_ref = a_seq[i]; a_dut = a_seq[i];
            if (i == 3) chk("a_no_early_done", 128'(a_done), 128'd0);
        end
        @(negedge clk);
        a_valid = 1'b0;
        chk("a_done", 128'(a_done), 128'd1);
        chk("a_signature", 128'(a_sig), 128'hF);
        chk("a_pass", 128'(a_pass), 128'd1);
        chk("a_count", 128'(a_cnt), 128'd0);

        // 2-bit counter: three mismatches, then a zero-length start from DONE
        @(negedge clk);
        b_start = 1'b1; b_num = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_start = 1'b0; b_valid = 1'b1; b_ref = 4'h0; b_dut = b_seq[i];
        end
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_done", 128'(b_done), 128'd1);
        chk("b_count_sat", 128'(b_cnt), 128'd3);
        chk("b_pass", 128'(b_pass), 128'd0);
        chk("b_ffc", 128'(b_ffc), 128'd0);
        chk("b_ffd", 128'(b_ffd), 128'h5);
        b_start = 1'b1; b_num = 2'd0;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_zero_done", 128'(b_done), 128'd1);
        chk("b_zero_pass", 128'(b_pass), 128'd1);
        chk("b_zero_count", 128'(b_cnt), 128'd0);
        chk("b_zero_sig", 128'(b_sig), 128'd0);
        chk("b_zero_busy", 128'(b_busy), 128'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
